mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction RAM between two requesters.
- Requester 0 is the CPU fetch/load-store path; requester 1 is the I/O or program-loader path.
- Sequences each access as ACCESS, plus a RESP cycle for reads, to match the RAM's 1-cycle synchronous read.
- Fixed priority to requester 0, with a starvation guard that forces a grant to requester 1 after MAX_CONSEC back-to-back CPU grants.

Parameters:
- ADDR_W, 9, RAM word-address width
- DATA_W, 16, RAM data width
- MAX_CONSEC, 3, maximum consecutive requester-0 grants while requester 1 is waiting (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 access request; held until gnt0
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 word address
- wdata0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 request accepted (1-cycle pulse)
- rvalid0  out  1  requester 0 read data valid (1-cycle pulse)
- rdata0  out  DATA_W  requester 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same widths and meanings for requester 1
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- States: IDLE, ACCESS, RESP. Registers: state, owner_q, we_q, addr_q, wdata_q, consec_cnt (4 bits).
- Reset: state=IDLE, consec_cnt=0, owner_q/we_q/addr_q/wdata_q=0. All outputs then read 0: gnt*, rvalid*, ram_we, ram_addr, ram_din, rdata*.
- IDLE, winner selection (combinational, same cycle):
  - Winner = 1 if req1 && (!req0 || consec_cnt==MAX_CONSEC).
  - Otherwise winner = 0 if req0.
  - Otherwise no winner; stay in IDLE.
- IDLE with a winner:
  - Winner's gnt asserted combinationally in that cycle.
  - At the edge, capture the winner's we/addr/wdata into the _q registers and move to ACCESS.
- gnt is only ever asserted in IDLE; at most one gnt high per cycle. A requester may drop or change req the cycle after gnt.
- ACCESS: ram_addr=addr_q, ram_din=wdata_q, ram_we=we_q && !rst.
  - Write: next state IDLE. Latency req-to-complete = 2 cycles; next grant possible 2 cycles after the previous gnt.
  - Read: next state RESP.
- RESP: rdata[owner_q]=ram_dout and rvalid[owner_q]=1 for exactly one cycle; next state IDLE. Read latency = rvalid 2 cycles after gnt.
- Outside ACCESS: ram_we=0, ram_addr=addr_q, ram_din=wdata_q. Outside RESP: rvalid*=0, rdata*=0.
- consec_cnt, updated only on a grant edge:
  - Grant to 0 with req1 high: consec_cnt+1, saturating at MAX_CONSEC.
  - Grant to 0 with req1 low: 0.
  - Grant to 1: 0.
- Requests arriving while in ACCESS or RESP are not sampled; they wait for IDLE. No queueing beyond the held req.
- Simultaneous req0 and req1 with consec_cnt<MAX_CONSEC: requester 0 wins.
- Reset mid-operation:
  - rst in ACCESS forces ram_we=0 that cycle; the write is dropped.
  - rst in ACCESS or RESP aborts a pending read: no rvalid is issued.
  - After reset, state=IDLE and consec_cnt=0.
- Address and data pass through unmodified; no width conversion and no bounds checking.

Test Plan:
- Reset: hold rst 2 cycles with req0=req1=1 -> gnt*, rvalid*, ram_we, ram_addr all 0; first gnt0 in the first cycle after rst deasserts.
- Single write then read (requester 0):
  - Stimulus: req0, we0=1, addr0=9'h05, wdata0=16'hABCD, followed by a read of 9'h05.
  - Required: gnt0 in cycle t, ram_we=1 with ram_addr=5 and ram_din=ABCD in t+1.
  - Read: rvalid0=1 and rdata0=ABCD exactly 2 cycles after its gnt0.
- Contention, MAX_CONSEC=3:
  - Stimulus: req0 and req1 held high continuously, all reads.
  - Required grant order 0,0,0,1,0,0,0,1.
  - Each rvalid goes to the matching owner only; gnt never overlaps an rvalid cycle.
- Requester-1 only: req1 write to 9'h1FF with data 16'h1234, then a read -> gnt1 while req0 low, ram_addr=1FF, rdata1=1234; rvalid0 never asserts.
- Reset mid-read: gnt0 for a read, assert rst in the RESP cycle -> rvalid0 stays 0; state returns to IDLE; consec_cnt=0.
- Reset mid-write: gnt1 for a write to 9'h10 with data 16'hFFFF, rst asserted in ACCESS -> ram_we=0 that cycle; a later read of 9'h10 returns the old value.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared single-port data/instruction RAM
// Requester 0 (CPU) has fixed priority; requester 1 is forced through after MAX_CONSEC CPU grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int MAX_CONSEC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  state_t              state;
  state_t              state_nxt;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          consec_cnt;

  logic                grant;
  logic                winner;

  // Requester 1 wins when the CPU is idle or has used up its consecutive-grant allowance.
  always_comb begin
    grant  = 1'b0;
    winner = 1'b0;
    if (state == IDLE) begin
      if (req1 && (!req0 || consec_cnt == MAX_CNT)) begin
        grant  = 1'b1;
        winner = 1'b1;
      end else if (req0) begin
        grant  = 1'b1;
        winner = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      consec_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_q <= winner;
        we_q    <= winner ? we1    : we0;
        addr_q  <= winner ? addr1  : addr0;
        wdata_q <= winner ? wdata1 : wdata0;
        if (!winner && req1) begin
          consec_cnt <= (consec_cnt == MAX_CNT) ? consec_cnt : consec_cnt + 4'd1;
        end else begin
          consec_cnt <= '0;
        end
      end
    end
  end

  // Outputs are gated by rst so an in-flight write is dropped and a pending read never reports.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_din   = wdata_q;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ACCESS;
          gnt0      = !winner && !rst;
          gnt1      = winner && !rst;
        end
      end
      ACCESS: begin
        ram_we    = we_q && !rst;
        state_nxt = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (!rst) begin
          if (owner_q) begin
            rvalid1 = 1'b1;
            rdata1  = ram_dout;
          end else begin
            rvalid0 = 1'b1;
            rdata0  = ram_dout;
          end
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
